// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port RAM: round-robin with a bounded burst hold,
// registered RAM pins and an owner-tagged read-return pipeline.
module ram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  write_enb,
    output logic                  read_enb,
    input  logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned TagDepth = RD_LATENCY + 1;
    localparam int unsigned CntWidth = $clog2(BURST_LEN + 1);
    localparam logic [CntWidth-1:0] BurstMax = CntWidth'(BURST_LEN);
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e              state_q;
    logic [CntWidth-1:0] cnt_q;
    logic                ptr_q;        // favoured requester when both contend from idle
    logic                pin_owner_q;  // requester whose command sits on the RAM pins
    logic [TagDepth-1:0] tag_valid_q;
    logic [TagDepth-1:0] tag_owner_q;

    logic hold;
    logic any_gnt;
    logic win;
    logic same_owner;

    assign hold = (cnt_q < BurstMax);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (req0 && req1) begin
                unique case (state_q)
                    StOwn0: begin
                        gnt0 = hold;
                        gnt1 = ~hold;
                    end
                    StOwn1: begin
                        gnt1 = hold;
                        gnt0 = ~hold;
                    end
                    default: begin
                        gnt0 = ~ptr_q;
                        gnt1 = ptr_q;
                    end
                endcase
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign any_gnt    = gnt0 | gnt1;
    assign win        = gnt1;
    assign same_owner = (gnt0 && (state_q == StOwn0)) || (gnt1 && (state_q == StOwn1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            pin_owner_q <= 1'b0;
            address     <= '0;
            data_in     <= '0;
            write_enb   <= 1'b0;
            read_enb    <= 1'b0;
        end else begin
            write_enb <= 1'b0;
            read_enb  <= 1'b0;
            if (any_gnt) begin
                state_q     <= win ? StOwn1 : StOwn0;
                pin_owner_q <= win;
                address     <= win ? addr1 : addr0;
                data_in     <= win ? wdata1 : wdata0;
                write_enb   <= win ? we1 : we0;
                read_enb    <= win ? ~we1 : ~we0;
                if (same_owner) begin
                    if (hold) begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end else begin
                    cnt_q <= CntOne;
                    ptr_q <= ~win;
                end
            end else begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end
        end
    end

    // Tags follow the registered pins, so the last stage lines up with data_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid_q <= '0;
            tag_owner_q <= '0;
        end else begin
            tag_valid_q <= {tag_valid_q[TagDepth-2:0], read_enb};
            tag_owner_q <= {tag_owner_q[TagDepth-2:0], pin_owner_q};
        end
    end

    assign rvalid0 = tag_valid_q[TagDepth-1] & ~tag_owner_q[TagDepth-1];
    assign rvalid1 = tag_valid_q[TagDepth-1] & tag_owner_q[TagDepth-1];
    assign rdata   = (rvalid0 | rvalid1) ? data_out : '0;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) !(gnt0 && gnt1));
    a_pins_excl:  assert property (@(posedge clk) disable iff (!reset) !(write_enb && read_enb));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, behavioural arbiter model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_port_arbiter;

    localparam int RD_LATENCY = 1;
    localparam int BURST_LEN  = 4;
    localparam int RvOfs      = 2 + RD_LATENCY;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata, address, data_in, data_out;
    logic       write_enb, read_enb;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .RD_LATENCY(RD_LATENCY),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .address  (address),
        .data_in  (data_in),
        .write_enb(write_enb),
        .read_enb (read_enb),
        .data_out (data_out)
    );

    // RAM: samples pins on the edge after acceptance, data_out valid RD_LATENCY later.
    logic [7:0] ram_mem  [256];
    logic [7:0] ram_pipe [RD_LATENCY+1];
    always @(posedge clk) begin
        if (write_enb) ram_mem[address] <= data_in;
        ram_pipe[0] <= read_enb ? ram_mem[address] : 8'hEE;
        for (int i = 1; i <= RD_LATENCY; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign data_out = ram_pipe[RD_LATENCY];

    function automatic void chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model state
    int         cyc_n  = 0;
    int         m_last = -1;   // current owner, -1 when nobody holds the RAM
    int         m_run  = 0;    // consecutive grants to m_last (saturating)
    int         m_ptr  = 0;
    logic [7:0] mdl_mem [256];
    logic       e_we = 1'b0, e_re = 1'b0;
    logic [7:0] e_addr, e_din;
    bit         ring_v [8];
    int         ring_o [8];
    logic [7:0] ring_d [8];
    bit         g_seen0, g_seen1;
    int         mw, midx, mj;
    logic       cw;
    logic [7:0] ca, cd;
    int         gnt_log [$];
    int         rv_own [$], rv_dat [$], rv_cyc [$];
    int         re_count = 0;

    always @(negedge clk) begin
        midx = cyc_n % 8;
        if (!reset) begin
            chk("reset_gnt", int'({gnt1, gnt0}), 0);
            chk("reset_pins", int'({address, data_in, write_enb, read_enb}), 0);
            chk("reset_rvalid_rdata", int'({rvalid1, rvalid0, rdata}), 0);
            m_last = -1; m_run = 0; m_ptr = 0;
            e_we = 1'b0; e_re = 1'b0;
            for (int i = 0; i < 8; i++) ring_v[i] = 1'b0;
            g_seen0 = 1'b0; g_seen1 = 1'b0;
        end else begin
            mw = -1;
            if (req0 && req1) begin
                if (m_last < 0) mw = m_ptr;
                else if (m_run < BURST_LEN) mw = m_last;
                else mw = 1 - m_last;
            end else if (req0) mw = 0;
            else if (req1) mw = 1;

            chk("gnt", int'({gnt1, gnt0}), (mw < 0) ? 0 : ((mw == 0) ? 1 : 2));
            chk("ram_enables", int'({write_enb, read_enb}), int'({e_we, e_re}));
            if (e_we || e_re) chk("ram_address", int'(address), int'(e_addr));
            if (e_we) chk("ram_data_in", int'(data_in), int'(e_din));
            chk("rvalid", int'({rvalid1, rvalid0}), ring_v[midx] ? ((ring_o[midx] == 1) ? 2 : 1) : 0);
            if (ring_v[midx]) chk("rdata", int'(rdata), int'(ring_d[midx]));
            if (rvalid0 || rvalid1) begin
                rv_own.push_back(rvalid1 ? 1 : 0);
                rv_dat.push_back(int'(rdata));
                rv_cyc.push_back(cyc_n);
            end
            if (read_enb) re_count++;
            ring_v[midx] = 1'b0;

            if (mw >= 0) begin
                if (mw == m_last) begin
                    if (m_run < BURST_LEN) m_run++;
                end else begin
                    m_run = 1;
                    m_ptr = 1 - mw;
                end
                m_last = mw;
                cw = (mw == 1) ? we1 : we0;
                ca = (mw == 1) ? addr1 : addr0;
                cd = (mw == 1) ? wdata1 : wdata0;
                e_we = cw; e_re = ~cw; e_addr = ca; e_din = cd;
                if (cw) mdl_mem[ca] = cd;
                else begin
                    mj = (cyc_n + RvOfs) % 8;
                    ring_v[mj] = 1'b1; ring_o[mj] = mw; ring_d[mj] = mdl_mem[ca];
                end
            end else begin
                m_last = -1; m_run = 0;
                e_we = 1'b0; e_re = 1'b0;
            end
            gnt_log.push_back(mw);
            g_seen0 = gnt0; g_seen1 = gnt1;
        end
        cyc_n++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic rv_clear();
        rv_own.delete(); rv_dat.delete(); rv_cyc.delete();
    endtask

    task automatic rand_phase(input int n);
        for (int k = 0; k < n; k++) begin
            cyc();
            if (!req0 || g_seen0) begin
                if ($urandom_range(0, 99) < 60) begin
                    req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
                    addr0 = 8'($urandom_range(0, 15)); wdata0 = 8'($urandom);
                end else req0 = 1'b0;
            end else if ($urandom_range(0, 15) == 0) req0 = 1'b0;
            if (!req1 || g_seen1) begin
                if ($urandom_range(0, 99) < 60) begin
                    req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
                    addr1 = 8'($urandom_range(0, 15)); wdata1 = 8'($urandom);
                end else req1 = 1'b0;
            end else if ($urandom_range(0, 15) == 0) req1 = 1'b0;
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                cyc(); cyc();
                reset = 1'b1;
            end
        end
    endtask

    int exp_burst [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int t_gnt, ones;

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        #2 reset = 1'b0;

        // Reset with both requesting, then sustained contention
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = 8'h20; addr1 = 8'h21; wdata0 = 8'h5A; wdata1 = 8'hC3;
        repeat (3) cyc();
        reset = 1'b1;
        gnt_log.delete();
        repeat (12) settle();
        chk("burst_log_len", gnt_log.size(), 12);
        for (int i = 0; i < 12 && i < gnt_log.size(); i++) chk("burst_pattern", gnt_log[i], exp_burst[i]);
        cyc();
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) cyc();

        // Fill addresses 0..15 with 0x11*i
        for (int i = 0; i < 16; i++) begin
            req0 = 1'b1; we0 = 1'b1; addr0 = 8'(i); wdata0 = 8'(i * 17);
            cyc();
        end
        req0 = 1'b0;
        repeat (3) cyc();

        // Only R1 for 10 cycles
        re_count = 0;
        gnt_log.delete();
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
        repeat (10) cyc();
        req1 = 1'b0;
        repeat (5) cyc();
        ones = 0;
        for (int i = 0; i < 10 && i < gnt_log.size(); i++) if (gnt_log[i] == 1) ones++;
        chk("r1_only_gnts", ones, 10);
        chk("r1_only_read_enb", re_count, 10);

        // Write then read of 0x10
        rv_clear();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
        cyc();
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
        settle();
        chk("t2_write_pins", int'({write_enb, read_enb, address, data_in}), 'h210A5);
        chk("t2_gnt1", gnt_log[$], 1);
        t_gnt = cyc_n - 1;
        cyc();
        req1 = 1'b0;
        settle();
        chk("t2_read_pins", int'({write_enb, read_enb, address}), 'h110);
        repeat (6) cyc();
        chk("t2_rv_count", rv_own.size(), 1);
        if (rv_own.size() > 0) begin
            chk("t2_rv_owner", rv_own[0], 1);
            chk("t2_rdata", rv_dat[0], 'hA5);
            chk("t2_rv_delay", rv_cyc[0] - t_gnt, 3);
        end

        // Back-to-back reads alternating owners
        rv_clear();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
        cyc();
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
        cyc();
        req1 = 1'b0; req0 = 1'b1; addr0 = 8'h03;
        cyc();
        req0 = 1'b0;
        repeat (6) cyc();
        chk("t5_rv_count", rv_own.size(), 3);
        if (rv_own.size() == 3) begin
            chk("t5_owner0", rv_own[0], 0);
            chk("t5_owner1", rv_own[1], 1);
            chk("t5_owner2", rv_own[2], 0);
            chk("t5_data0", rv_dat[0], 'h11);
            chk("t5_data1", rv_dat[1], 'h22);
            chk("t5_data2", rv_dat[2], 'h33);
            chk("t5_consecutive", (rv_cyc[1] - rv_cyc[0]) * 10 + (rv_cyc[2] - rv_cyc[1]), 11);
        end

        // Reset one cycle after an accepted read
        rv_clear();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h07;
        cyc();
        req0 = 1'b0;
        cyc();
        reset = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        repeat (6) cyc();
        chk("t6_no_rvalid", rv_own.size(), 0);
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = 8'h20; addr1 = 8'h21;
        settle();
        chk("t6_ptr_r0", gnt_log[$], 0);
        cyc();
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) cyc();

        rand_phase(3000);
        req0 = 1'b0; req1 = 1'b0;
        repeat (8) cyc();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
